// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
// Holds the transmitter state encoding, keyboard command bytes and the line idle level.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT1     = 3'd3,
    S_BITS      = 3'd4,
    S_ACK       = 3'd5,
    S_WAIT_IDLE = 3'd6,
    S_FAIL      = 3'd7
  } ps2_state_t;

  localparam logic [7:0] CMD_LEDS      = 8'hED;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

  // Both PS/2 lines are open-collector with pull-ups, so released means high.
  localparam logic LINE_IDLE = 1'b1;

  localparam int TIMER_W = 19;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, stability filter, and a
// registered one-cycle strobe on each accepted 1->0 transition.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER) + 1;

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic             fall_reg;
  logic [CNT_W-1:0] stable_cnt_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_reg       <= {2{LINE_IDLE}};
      level_reg      <= LINE_IDLE;
      fall_reg       <= 1'b0;
      stable_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      fall_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        stable_cnt_reg <= '0;
      end else if (stable_cnt_reg == CNT_W'(FILTER - 1)) begin
        // New level has differed for FILTER consecutive cycles: accept it.
        level_reg      <= sync_reg[1];
        fall_reg       <= level_reg;
        stable_cnt_reg <= '0;
      end else begin
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the request-to-send,
// shifts data/parity/stop out on device clock falls and checks the device ack.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 3000,
  parameter int START_TMO   = 375000,
  parameter int XFER_TMO    = 50000,
  parameter int FILTER      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clock_i,
  input  logic       ps_data_i,
  output logic       ps_clock_oe,
  output logic       ps_data_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Index 0 = clock line, index 1 = data line.
  logic [1:0] line_raw;
  logic [1:0] line_level;
  logic [1:0] line_fall;

  assign line_raw = {ps_data_i, ps_clock_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filter
      ps2_line_filter #(.FILTER(FILTER)) u_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (line_raw[gi]),
        .level   (line_level[gi]),
        .fall    (line_fall[gi])
      );
    end
  endgenerate

  logic clk_level, dat_level, clk_fall;
  logic unused_data_fall;

  assign clk_level        = line_level[0];
  assign dat_level        = line_level[1];
  assign clk_fall         = line_fall[0];
  assign unused_data_fall = line_fall[1];

  ps2_state_t         state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next, timer_inc;
  logic [3:0]         cnt_reg, cnt_next;
  logic [9:0]         sh_reg, sh_next;
  logic               clock_oe_reg, clock_oe_next;
  logic               data_oe_reg, data_oe_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic               fail_go;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      cnt_reg      <= '0;
      sh_reg       <= '0;
      clock_oe_reg <= 1'b0;
      data_oe_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      cnt_reg      <= cnt_next;
      sh_reg       <= sh_next;
      clock_oe_reg <= clock_oe_next;
      data_oe_reg  <= data_oe_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  assign timer_inc = (&timer_reg) ? timer_reg : timer_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    cnt_next      = cnt_reg;
    sh_next       = sh_reg;
    clock_oe_next = clock_oe_reg;
    data_oe_next  = data_oe_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = error_reg;
    fail_go       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        // A send landing on the done cycle belongs to the finished transaction.
        if (send && !done_reg) begin
          sh_next       = {1'b1, odd_parity(data), data};
          cnt_next      = '0;
          timer_next    = '0;
          error_next    = 1'b0;
          busy_next     = 1'b1;
          clock_oe_next = 1'b1;
          state_next    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_reg == TIMER_W'(INHIBIT_CYC - 1)) begin
          data_oe_next = 1'b1;
          state_next   = S_REQ;
        end else begin
          timer_next = timer_inc;
        end
      end
      S_REQ: begin
        clock_oe_next = 1'b0;
        timer_next    = '0;
        state_next    = S_WAIT1;
      end
      S_WAIT1: begin
        if (clk_fall) begin
          data_oe_next = ~sh_reg[0];
          cnt_next     = 4'd1;
          timer_next   = '0;
          state_next   = S_BITS;
        end else if (timer_reg == TIMER_W'(START_TMO)) begin
          fail_go = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end
      S_BITS: begin
        if (timer_reg == TIMER_W'(XFER_TMO)) begin
          fail_go = 1'b1;
        end else begin
          timer_next = timer_inc;
          if (clk_fall) begin
            data_oe_next = ~sh_reg[cnt_reg];
            cnt_next     = cnt_reg + 4'd1;
            if (cnt_reg == 4'd9) state_next = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (timer_reg == TIMER_W'(XFER_TMO)) begin
          fail_go = 1'b1;
        end else begin
          timer_next = timer_inc;
          if (clk_fall) begin
            if (!dat_level) begin
              error_next = 1'b0;
              state_next = S_WAIT_IDLE;
            end else begin
              fail_go = 1'b1;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timer_reg == TIMER_W'(XFER_TMO)) begin
          fail_go = 1'b1;
        end else begin
          timer_next = timer_inc;
          if (clk_level && dat_level) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Failure outputs are set on entry so done/error appear in the FAIL cycle itself.
    if (fail_go) begin
      clock_oe_next = 1'b0;
      data_oe_next  = 1'b0;
      error_next    = 1'b1;
      done_next     = 1'b1;
      busy_next     = 1'b0;
      state_next    = S_FAIL;
    end
  end

  assign ps_clock_oe = clock_oe_reg;
  assign ps_data_oe  = data_oe_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a simple PS/2 device model on wired-AND lines.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INHIBIT_CYC = 60;
  localparam int START_TMO   = 400;
  localparam int XFER_TMO    = 2000;
  localparam int FILTER      = 8;
  localparam int HALF        = 25;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       send    = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       ps_clock_i, ps_data_i;
  logic       ps_clock_oe, ps_data_oe, busy, done, error;

  assign ps_clock_i = dev_clk & ~ps_clock_oe;
  assign ps_data_i  = dev_dat & ~ps_data_oe;

  int checks = 0;
  int errors = 0;

  int   done_cnt = 0;
  logic done_err, done_busy, done_coe, done_doe;

  always #20 clock = ~clock;

  ps2_tx #(
    .INHIBIT_CYC (INHIBIT_CYC),
    .START_TMO   (START_TMO),
    .XFER_TMO    (XFER_TMO),
    .FILTER      (FILTER)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ps_clock_i  (ps_clock_i),
    .ps_data_i   (ps_data_i),
    .ps_clock_oe (ps_clock_oe),
    .ps_data_oe  (ps_data_oe),
    .data        (data),
    .send        (send),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_err  = error;
      done_busy = busy;
      done_coe  = ps_clock_oe;
      done_doe  = ps_data_oe;
      done_cnt  = done_cnt + 1;
    end
  end

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: observed no finish, expected finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_send(input logic [7:0] d);
    @(negedge clock);
    data = d;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  // Device model: waits for clock release, clocks 10 bits, then the ack pulse.
  task automatic dev_xfer(input bit do_ack, input int glitch_pulse, input int stop_after,
                          input bit inject, output logic [10:0] frame);
    int n;
    frame = '0;
    n = 0;
    while (ps_clock_oe === 1'b1 && n < INHIBIT_CYC + 20) begin
      @(negedge clock);
      n++;
    end
    chk("inhibit_cycles", n, INHIBIT_CYC + 1);
    frame[0] = ps_data_i;
    repeat (30) @(negedge clock);
    for (int p = 1; p <= 10; p++) begin
      dev_clk = 1'b0;
      if (inject && p == 3) begin
        data = 8'h12;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        repeat (HALF - 1) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      dev_clk  = 1'b1;
      frame[p] = ps_data_i;
      if (glitch_pulse == p) begin
        repeat (8) @(negedge clock);
        dev_clk = 1'b0;
        repeat (3) @(negedge clock);
        dev_clk = 1'b1;
        repeat (HALF - 11) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
      if (p == stop_after) return;
    end
    repeat (5) @(negedge clock);
    dev_dat = do_ack ? 1'b0 : 1'b1;
    repeat (20) @(negedge clock);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    dev_clk = 1'b1;
    repeat (5) @(negedge clock);
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask

  logic [10:0] frame;
  logic [10:0] exp_frame;
  logic [7:0]  par_data [3];
  logic        par_exp  [3];
  int          base;
  int          n;
  bit          busy_seen;

  initial begin
    par_data = '{8'h00, 8'h01, 8'hFF};
    par_exp  = '{1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_clock_oe", ps_clock_oe, 1'b0);
    chk("rst_data_oe", ps_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // LED command 0xED, device acks
    base = done_cnt;
    start_send(CMD_LEDS);
    chk("led_busy_after_send", busy, 1'b1);
    chk("led_clock_oe_inhibit", ps_clock_oe, 1'b1);
    dev_xfer(1'b1, 0, 0, 1'b0, frame);
    wait_done(base + 1, "led_done");
    exp_frame = {1'b1, 1'b1, 8'hED, 1'b0};
    chk("led_frame", frame, exp_frame);
    chk("led_error", done_err, 1'b0);
    chk("led_busy_at_done", done_busy, 1'b0);
    repeat (50) @(negedge clock);
    chk("led_single_done", done_cnt, base + 1);

    // Parity cases
    for (int i = 0; i < 3; i++) begin
      base = done_cnt;
      start_send(par_data[i]);
      dev_xfer(1'b1, 0, 0, 1'b0, frame);
      wait_done(base + 1, "par_done");
      chk("par_bit", frame[9], par_exp[i]);
      chk("par_data", frame[8:1], par_data[i]);
      chk("par_error", done_err, 1'b0);
      repeat (20) @(negedge clock);
    end

    // send pulsed mid-transfer is ignored
    base = done_cnt;
    start_send(CMD_LEDS);
    dev_xfer(1'b1, 0, 0, 1'b1, frame);
    wait_done(base + 1, "ign_done");
    chk("ign_frame_data", frame[8:1], 8'hED);
    busy_seen = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
    end
    chk("ign_no_restart", busy_seen, 1'b0);
    chk("ign_one_done", done_cnt, base + 1);

    // Missing ack
    base = done_cnt;
    start_send(8'h3C);
    dev_xfer(1'b0, 0, 0, 1'b0, frame);
    wait_done(base + 1, "nack_done");
    chk("nack_error", done_err, 1'b1);
    chk("nack_clock_oe", done_coe, 1'b0);
    chk("nack_data_oe", done_doe, 1'b0);
    repeat (20) @(negedge clock);
    chk("nack_error_held", error, 1'b1);

    // No device: start timeout, plus a send coinciding with done
    base = done_cnt;
    start_send(8'h55);
    chk("nodev_error_cleared", error, 1'b0);
    n = 0;
    while (ps_clock_oe === 1'b1 && n < INHIBIT_CYC + 20) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (done !== 1'b1 && n < START_TMO + 50) begin
      @(negedge clock);
      n++;
    end
    chk("nodev_latency", n, START_TMO + 1);
    chk("nodev_error", error, 1'b1);
    chk("nodev_clock_oe", ps_clock_oe, 1'b0);
    chk("nodev_data_oe", ps_data_oe, 1'b0);
    data = 8'h12;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    chk("coinc_busy", busy, 1'b0);
    chk("coinc_clock_oe", ps_clock_oe, 1'b0);
    repeat (100) @(negedge clock);
    chk("coinc_no_done", done_cnt, base + 1);

    // Reset in the middle of BITS
    start_send(CMD_LEDS);
    dev_xfer(1'b1, 0, 5, 1'b0, frame);
    chk("midrst_pre_data_oe", ps_data_oe, 1'b1);
    chk("midrst_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_clock_oe", ps_clock_oe, 1'b0);
    chk("midrst_data_oe", ps_data_oe, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    // Fresh send after reset with a short clock glitch during BITS
    base = done_cnt;
    start_send(CMD_TYPEMATIC);
    dev_xfer(1'b1, 4, 0, 1'b0, frame);
    wait_done(base + 1, "fresh_done");
    exp_frame = {1'b1, 1'b1, 8'hF3, 1'b0};
    chk("fresh_glitch_frame", frame, exp_frame);
    chk("fresh_error", done_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
